cmos_capture_pack: RTL and testbench



---
 rtl/cmos_cap_pkg.sv | 24 ++
 rtl/cmos_byte_packer.sv | 59 +++++
 rtl/cmos_capture_pack.sv | 169 ++++++++++++++++
 tb/tb_cmos_capture_pack.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_cap_pkg.sv
// Shared definitions for the CMOS capture front end.
//   - cap_state_t : capture FSM state encoding
//   - CNT_W       : width of the line and pixel counters
//   - DEF_*       : default frame geometry (VGA)
//   - sat_inc     : saturating increment for CNT_W-wide counters
package cmos_cap_pkg;

  localparam int CNT_W        = 11;
  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_SKIP      = 2'd1,
    ST_CAPTURE   = 2'd2
  } cap_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cmos_byte_packer.sv
// Packs pairs of sensor bytes into one 16-bit RGB565 word.
// Ports:
//   clk, rst    : pixel clock, synchronous active-high reset
//   i_en        : byte at i_byte is a valid line byte this cycle
//   i_byte      : sensor byte (already registered by the caller)
//   i_clr       : return to phase 0 and drop any half-built pixel
//   i_kill      : capture aborted; clear phase and suppress the strobe
//   o_phase     : 1 when the first byte of a pixel is held
//   o_emit      : combinational, second byte accepted this cycle
//   o_pix_we    : one-cycle write strobe, the cycle after o_emit
//   o_pix_data  : packed pixel, valid while o_pix_we is high
module cmos_byte_packer #(
  parameter int BYTE_ORDER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  input  logic        i_clr,
  input  logic        i_kill,
  output logic        o_phase,
  output logic        o_emit,
  output logic        o_pix_we,
  output logic [15:0] o_pix_data
);

  logic        r_phase;
  logic [7:0]  r_first;
  logic        r_we;
  logic [15:0] r_data;

  assign o_emit     = i_en & r_phase & ~i_kill;
  assign o_phase    = r_phase;
  assign o_pix_we   = r_we;
  assign o_pix_data = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 1'b0;
      r_first <= 8'd0;
      r_we    <= 1'b0;
      r_data  <= 16'd0;
    end else begin
      r_we <= o_emit;
      if (o_emit) begin
        r_data <= (BYTE_ORDER == 0) ? {r_first, i_byte} : {i_byte, r_first};
      end
      if (i_kill || i_clr) begin
        r_phase <= 1'b0;
      end else if (i_en) begin
        r_phase <= ~r_phase;
      end
      if (i_en && !r_phase) begin
        r_first <= i_byte;
      end
    end
  end

endmodule

// File: rtl/cmos_capture_pack.sv
// CMOS sensor capture front end for the SDRAM frame store (pixel-clock domain).
// Turns vsync/href/byte input into RGB565 write strobes, skips the sensor's
// settling frames, requests a write-address reload at each captured frame
// start and flags malformed lines/frames.
// Ports:
//   clk, rst          : pixel clock, synchronous active-high reset
//   cmos_vsync/href   : sensor frame / line sync
//   cmos_data         : sensor byte
//   sdram_init_done   : asynchronous, synchronised here (2 flops)
//   frame_wr_load     : LOAD_CYC-cycle reload request at captured frame start
//   pix_we, pix_data  : write strobe and pixel for the write FIFO
//   capture_on        : FSM in CAPTURE
//   frame_done        : one-cycle pulse when a good frame completes
//   frame_cnt         : good-frame count (wraps)
//   line_err          : sticky per-frame malformed line/frame flag
//   dbg_state         : current FSM state (cap_state_t encoding)
// pix_we is a push-only strobe: one word per high cycle, the FIFO never
// back-pressures, so there is no ready and data is valid only while pix_we=1.
module cmos_capture_pack
  import cmos_cap_pkg::*;
#(
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int V_LINES    = DEF_V_LINES,
  parameter int FRAME_SKIP = 10,
  parameter int VSYNC_POL  = 1,
  parameter int BYTE_ORDER = 0,
  parameter int LOAD_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        sdram_init_done,
  output logic        frame_wr_load,
  output logic        pix_we,
  output logic [15:0] pix_data,
  output logic        capture_on,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        line_err,
  output logic [1:0]  dbg_state
);

  localparam logic [CNT_W-1:0] H_PIX_C  = CNT_W'(H_PIXELS);
  localparam logic [CNT_W-1:0] V_LIN_C  = CNT_W'(V_LINES);
  localparam logic [7:0]       SKIP_N   = 8'(FRAME_SKIP);
  localparam logic [3:0]       LOAD_N   = 4'(LOAD_CYC);

  logic             r_vs1, r_vs2, r_href1, r_href2;
  logic [7:0]       r_data1;
  logic             r_init_m, r_init_s;
  cap_state_t       r_state, w_next;
  logic [7:0]       r_skip_cnt;
  logic [3:0]       r_load_cnt;
  logic [CNT_W-1:0] r_line_cnt, r_pix_cnt;
  logic             r_line_err, r_frame_done;
  logic [7:0]       r_frame_cnt;

  logic             w_vs_in, w_vs_edge, w_href_fall, w_line_end;
  logic             w_frame_start, w_good_frame, w_err_upd;
  logic [CNT_W-1:0] w_line_cnt_upd;
  logic             w_pk_en, w_pk_clr, w_pk_kill, w_phase, w_emit;

  // Internally vsync is active-high regardless of the sensor's polarity.
  assign w_vs_in     = (VSYNC_POL != 0) ? cmos_vsync : ~cmos_vsync;
  assign w_vs_edge   = r_vs1 & ~r_vs2;
  assign w_href_fall = r_href2 & ~r_href1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT_INIT: if (r_init_s) w_next = ST_SKIP;
      ST_SKIP: begin
        if (!r_init_s) w_next = ST_WAIT_INIT;
        else if (w_vs_edge && (r_skip_cnt == SKIP_N)) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: if (!r_init_s) w_next = ST_WAIT_INIT;
      default: w_next = ST_WAIT_INIT;
    endcase
  end

  // The line being closed is judged by the vsync level that accompanied its
  // last byte (stage 2), so a line ending on the same cycle as a vs_edge is
  // still booked before the frame-start clears below.
  assign w_line_end     = (r_state == ST_CAPTURE) && w_href_fall && !r_vs2;
  assign w_line_cnt_upd = w_line_end ? sat_inc(r_line_cnt) : r_line_cnt;
  assign w_err_upd      = r_line_err | (w_line_end & ((r_pix_cnt != H_PIX_C) | w_phase |
                                                      (sat_inc(r_line_cnt) > V_LIN_C)));
  assign w_frame_start  = w_vs_edge && (w_next == ST_CAPTURE);
  // Only a frame that was captured from its start can be a good frame.
  assign w_good_frame   = w_frame_start && (r_state == ST_CAPTURE) &&
                          (w_line_cnt_upd == V_LIN_C) && !w_err_upd;

  assign w_pk_en   = (r_state == ST_CAPTURE) & r_init_s & r_href1 & ~r_vs1;
  assign w_pk_clr  = w_frame_start | w_line_end;
  assign w_pk_kill = (r_state != ST_CAPTURE) | ~r_init_s;

  cmos_byte_packer #(.BYTE_ORDER(BYTE_ORDER)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_pk_en),
    .i_byte     (r_data1),
    .i_clr      (w_pk_clr),
    .i_kill     (w_pk_kill),
    .o_phase    (w_phase),
    .o_emit     (w_emit),
    .o_pix_we   (pix_we),
    .o_pix_data (pix_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs1        <= 1'b0;
      r_vs2        <= 1'b0;
      r_href1      <= 1'b0;
      r_href2      <= 1'b0;
      r_data1      <= 8'd0;
      r_init_m     <= 1'b0;
      r_init_s     <= 1'b0;
      r_state      <= ST_WAIT_INIT;
      r_skip_cnt   <= 8'd0;
      r_load_cnt   <= 4'd0;
      r_line_cnt   <= '0;
      r_pix_cnt    <= '0;
      r_line_err   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'd0;
    end else begin
      r_vs1    <= w_vs_in;
      r_vs2    <= r_vs1;
      r_href1  <= cmos_href;
      r_href2  <= r_href1;
      r_data1  <= cmos_data;
      r_init_m <= sdram_init_done;
      r_init_s <= r_init_m;
      r_state  <= w_next;

      if (r_state == ST_WAIT_INIT) r_skip_cnt <= 8'd0;
      else if (r_state == ST_SKIP && w_vs_edge) r_skip_cnt <= r_skip_cnt + 8'd1;

      if (!r_init_s) r_load_cnt <= 4'd0;
      else if (w_frame_start) r_load_cnt <= LOAD_N;
      else if (r_load_cnt != 4'd0) r_load_cnt <= r_load_cnt - 4'd1;

      r_frame_done <= w_good_frame;
      if (w_good_frame) r_frame_cnt <= r_frame_cnt + 8'd1;

      if (w_frame_start || r_state != ST_CAPTURE) begin
        r_line_cnt <= '0;
        r_pix_cnt  <= '0;
        r_line_err <= 1'b0;
      end else begin
        r_line_cnt <= w_line_cnt_upd;
        r_line_err <= w_err_upd;
        if (w_line_end) r_pix_cnt <= '0;
        else if (w_emit) r_pix_cnt <= sat_inc(r_pix_cnt);
      end
    end
  end

  assign frame_wr_load = (r_load_cnt != 4'd0);
  assign capture_on    = (r_state == ST_CAPTURE);
  assign frame_done    = r_frame_done;
  assign frame_cnt     = r_frame_cnt;
  assign line_err      = r_line_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_cmos_capture_pack.sv
module tb_cmos_capture_pack;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmos_vsync, cmos_href, sdram_init_done;
  logic [7:0]  cmos_data;
  logic        load0, we0, cap0, done0, err0, load1, we1, cap1, done1, err1;
  logic [15:0] data0, data1;
  logic [7:0]  fcnt0, fcnt1;
  logic [1:0]  st0, st1;

  cmos_capture_pack #(.H_PIXELS(4), .V_LINES(2), .FRAME_SKIP(2), .VSYNC_POL(1),
                      .BYTE_ORDER(0), .LOAD_CYC(4)) dut0 (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .sdram_init_done(sdram_init_done),
    .frame_wr_load(load0), .pix_we(we0), .pix_data(data0), .capture_on(cap0),
    .frame_done(done0), .frame_cnt(fcnt0), .line_err(err0), .dbg_state(st0));

  cmos_capture_pack #(.H_PIXELS(4), .V_LINES(2), .FRAME_SKIP(2), .VSYNC_POL(1),
                      .BYTE_ORDER(1), .LOAD_CYC(4)) dut1 (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .sdram_init_done(sdram_init_done),
    .frame_wr_load(load1), .pix_we(we1), .pix_data(data1), .capture_on(cap1),
    .frame_done(done1), .frame_cnt(fcnt1), .line_err(err1), .dbg_state(st1));

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp0_q[$], exp1_q[$], obs0_q[$], obs1_q[$];
  int          we_cyc_q[$], load_q[$];
  int          load_run = 0;
  int          done_cnt = 0;
  int          c_second = 0;
  logic [7:0]  lb[0:15];

  // Observation only: records strobes, reload widths and done pulses.
  always @(negedge clk) begin
    if (we0) begin obs0_q.push_back(data0); we_cyc_q.push_back(cyc); end
    if (we1) obs1_q.push_back(data1);
    if (load0) load_run++;
    else if (load_run != 0) begin load_q.push_back(load_run); load_run = 0; end
    if (done0) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_line(input logic [7:0] base);
    for (int i = 0; i < 16; i++) lb[i] = base + 8'(i);
  endtask

  task automatic send_line(input int n, input bit cap);
    for (int i = 0; i < n; i++) begin
      cmos_href = 1'b1;
      cmos_data = lb[i];
      if (i == 1) c_second = cyc;
      step();
    end
    cmos_href = 1'b0;
    cmos_data = 8'd0;
    repeat (3) step();
    if (cap) begin
      for (int k = 0; k + 1 < n; k += 2) begin
        exp0_q.push_back({lb[k], lb[k+1]});
        exp1_q.push_back({lb[k+1], lb[k]});
      end
    end
  endtask

  task automatic send_vsync();
    cmos_href  = 1'b0;
    cmos_vsync = 1'b1;
    repeat (3) step();
    cmos_vsync = 1'b0;
    repeat (8) step();
  endtask

  task automatic send_frame(input int nl, input logic [7:0] base, input bit cap);
    send_vsync();
    for (int l = 0; l < nl; l++) begin
      fill_line(base + 8'(l * 16));
      send_line(8, cap);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int b0, bl;
    rst = 1'b1; cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_data = 8'd0; sdram_init_done = 1'b0;
    repeat (3) step();
    n_vec++; if (we0 !== 1'b0) begin n_err++; $display("FAIL reset_pix_we: got %b want 0", we0); end
    n_vec++; if (load0 !== 1'b0) begin n_err++; $display("FAIL reset_load: got %b want 0", load0); end
    n_vec++; if (data0 !== 16'h0000) begin n_err++; $display("FAIL reset_pix_data: got %h want 0000", data0); end
    n_vec++; if (cap0 !== 1'b0) begin n_err++; $display("FAIL reset_capture_on: got %b want 0", cap0); end
    n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", done0); end
    n_vec++; if (fcnt0 !== 8'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", fcnt0); end
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL reset_line_err: got %b want 0", err0); end
    n_vec++; if (st0 !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", st0); end
    rst = 1'b0;
    b0 = obs0_q.size(); bl = load_q.size();
    send_frame(2, 8'h10, 1'b0);
    send_frame(2, 8'h30, 1'b0);
    send_vsync();
    n_vec++; if (obs0_q.size() - b0 != 0) begin n_err++; $display("FAIL noinit_pix_we: got %0d strobes want 0", obs0_q.size() - b0); end
    n_vec++; if (load_q.size() - bl != 0 || load_run != 0) begin n_err++; $display("FAIL noinit_load: got %0d pulses want 0", load_q.size() - bl); end
    n_vec++; if (st0 !== 2'd0) begin n_err++; $display("FAIL noinit_state: got %0d want 0", st0); end
  endtask

  task automatic test_skip_capture();
    int b0, b1, bl, bd;
    sdram_init_done = 1'b1;
    repeat (4) step();
    exp0_q.delete(); exp1_q.delete();
    b0 = obs0_q.size(); b1 = obs1_q.size(); bl = load_q.size(); bd = done_cnt;
    send_frame(2, 8'h20, 1'b0);
    send_frame(2, 8'h40, 1'b0);
    n_vec++; if (obs0_q.size() - b0 != 0) begin n_err++; $display("FAIL skip_pix_we: got %0d strobes want 0", obs0_q.size() - b0); end
    n_vec++; if (cap0 !== 1'b0) begin n_err++; $display("FAIL skip_capture_on: got %b want 0", cap0); end
    send_frame(2, 8'h60, 1'b1);
    n_vec++; if (obs0_q.size() - b0 != 8) begin n_err++; $display("FAIL frame3_pix_we: got %0d strobes want 8", obs0_q.size() - b0); end
    n_vec++; if (done_cnt - bd != 0) begin n_err++; $display("FAIL frame3_done: got %0d pulses want 0", done_cnt - bd); end
    send_frame(2, 8'h80, 1'b1);
    n_vec++; if (obs0_q.size() - b0 != 16) begin n_err++; $display("FAIL frame4_pix_we: got %0d strobes want 16", obs0_q.size() - b0); end
    n_vec++; if (load_q.size() - bl != 2) begin n_err++; $display("FAIL load_pulses: got %0d want 2", load_q.size() - bl); end
    for (int i = bl; i < load_q.size(); i++) begin
      n_vec++; if (load_q[i] != 4) begin n_err++; $display("FAIL load_width: got %0d want 4", load_q[i]); end
    end
    n_vec++; if (done_cnt - bd != 1) begin n_err++; $display("FAIL frame4_done: got %0d pulses want 1", done_cnt - bd); end
    n_vec++; if (fcnt0 !== 8'd1) begin n_err++; $display("FAIL frame4_cnt: got %0d want 1", fcnt0); end
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL frame4_line_err: got %b want 0", err0); end
    for (int i = 0; i < exp0_q.size(); i++) begin
      n_vec++;
      if (b0 + i >= obs0_q.size() || obs0_q[b0+i] !== exp0_q[i]) begin
        n_err++; $display("FAIL pix0[%0d]: got %h want %h", i, (b0 + i < obs0_q.size()) ? obs0_q[b0+i] : 16'hxxxx, exp0_q[i]);
      end
    end
    for (int i = 0; i < exp1_q.size(); i++) begin
      n_vec++;
      if (b1 + i >= obs1_q.size() || obs1_q[b1+i] !== exp1_q[i]) begin
        n_err++; $display("FAIL pix1[%0d]: got %h want %h", i, (b1 + i < obs1_q.size()) ? obs1_q[b1+i] : 16'hxxxx, exp1_q[i]);
      end
    end
  endtask

  task automatic test_byte_order();
    int b0, b1, bw;
    send_vsync();
    n_vec++; if (fcnt0 !== 8'd2) begin n_err++; $display("FAIL frame5_cnt: got %0d want 2", fcnt0); end
    b0 = obs0_q.size(); b1 = obs1_q.size(); bw = we_cyc_q.size();
    lb[0] = 8'hF8; lb[1] = 8'h1F; lb[2] = 8'h00; lb[3] = 8'h11;
    lb[4] = 8'h22; lb[5] = 8'h33; lb[6] = 8'h44; lb[7] = 8'h55;
    send_line(8, 1'b0);
    n_vec++; if (obs0_q.size() - b0 != 4) begin n_err++; $display("FAIL order_count: got %0d want 4", obs0_q.size() - b0); end
    if (obs0_q.size() - b0 >= 2 && obs1_q.size() - b1 >= 2 && we_cyc_q.size() - bw >= 2) begin
      n_vec++; if (obs0_q[b0] !== 16'hF81F) begin n_err++; $display("FAIL order0_first: got %h want F81F", obs0_q[b0]); end
      n_vec++; if (obs1_q[b1] !== 16'h1FF8) begin n_err++; $display("FAIL order1_first: got %h want 1FF8", obs1_q[b1]); end
      n_vec++; if (obs0_q[b0+1] !== 16'h0011) begin n_err++; $display("FAIL order0_second: got %h want 0011", obs0_q[b0+1]); end
      n_vec++; if (obs1_q[b1+1] !== 16'h1100) begin n_err++; $display("FAIL order1_second: got %h want 1100", obs1_q[b1+1]); end
      n_vec++; if (we_cyc_q[bw] != c_second + 2) begin n_err++; $display("FAIL latency: got %0d cycles want 2", we_cyc_q[bw] - c_second); end
      n_vec++; if (we_cyc_q[bw+1] - we_cyc_q[bw] != 2) begin n_err++; $display("FAIL strobe_spacing: got %0d want 2", we_cyc_q[bw+1] - we_cyc_q[bw]); end
    end else begin
      n_vec++; n_err++; $display("FAIL order_missing: got %0d strobes want 4", obs0_q.size() - b0);
    end
    fill_line(8'hA0);
    send_line(8, 1'b0);
  endtask

  task automatic test_odd_line();
    int b0, bd;
    send_vsync();
    n_vec++; if (fcnt0 !== 8'd3) begin n_err++; $display("FAIL frame6_cnt: got %0d want 3", fcnt0); end
    b0 = obs0_q.size();
    fill_line(8'hB0);
    send_line(7, 1'b0);
    n_vec++; if (obs0_q.size() - b0 != 3) begin n_err++; $display("FAIL odd_count: got %0d want 3", obs0_q.size() - b0); end
    n_vec++; if (err0 !== 1'b1) begin n_err++; $display("FAIL odd_line_err: got %b want 1", err0); end
    fill_line(8'hC0);
    send_line(8, 1'b0);
    n_vec++; if (err0 !== 1'b1) begin n_err++; $display("FAIL odd_sticky: got %b want 1", err0); end
    bd = done_cnt;
    send_vsync();
    n_vec++; if (done_cnt - bd != 0) begin n_err++; $display("FAIL odd_done: got %0d pulses want 0", done_cnt - bd); end
    n_vec++; if (fcnt0 !== 8'd3) begin n_err++; $display("FAIL odd_cnt: got %0d want 3", fcnt0); end
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL odd_err_clear: got %b want 0", err0); end
  endtask

  task automatic test_extra_line();
    for (int l = 0; l < 2; l++) begin fill_line(8'h10 + 8'(l * 16)); send_line(8, 1'b0); end
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL extra_two_lines: got %b want 0", err0); end
    fill_line(8'h50);
    send_line(8, 1'b0);
    n_vec++; if (err0 !== 1'b1) begin n_err++; $display("FAIL extra_third_line: got %b want 1", err0); end
    send_vsync();
    n_vec++; if (fcnt0 !== 8'd3) begin n_err++; $display("FAIL extra_cnt: got %0d want 3", fcnt0); end
  endtask

  task automatic test_init_drop();
    int bw, d, late, b0, b1, bl;
    fill_line(8'h60);
    for (int i = 0; i < 4; i++) begin cmos_href = 1'b1; cmos_data = lb[i]; step(); end
    bw = we_cyc_q.size();
    sdram_init_done = 1'b0;
    d = cyc;
    for (int i = 4; i < 16; i++) begin cmos_href = 1'b1; cmos_data = lb[i]; step(); end
    cmos_href = 1'b0;
    repeat (3) step();
    late = 0;
    for (int i = bw; i < we_cyc_q.size(); i++) if (we_cyc_q[i] >= d + 3) late++;
    n_vec++; if (late != 0) begin n_err++; $display("FAIL drop_pix_we: got %0d late strobes want 0", late); end
    n_vec++; if (cap0 !== 1'b0) begin n_err++; $display("FAIL drop_capture_on: got %b want 0", cap0); end
    n_vec++; if (st0 !== 2'd0) begin n_err++; $display("FAIL drop_state: got %0d want 0", st0); end
    sdram_init_done = 1'b1;
    repeat (4) step();
    exp0_q.delete(); exp1_q.delete();
    b0 = obs0_q.size(); b1 = obs1_q.size(); bl = load_q.size();
    send_frame(2, 8'h70, 1'b0);
    send_frame(2, 8'h90, 1'b0);
    n_vec++; if (obs0_q.size() - b0 != 0) begin n_err++; $display("FAIL resume_skip: got %0d strobes want 0", obs0_q.size() - b0); end
    send_frame(2, 8'hD0, 1'b1);
    n_vec++; if (obs0_q.size() - b0 != 8) begin n_err++; $display("FAIL resume_count: got %0d want 8", obs0_q.size() - b0); end
    n_vec++; if (load_q.size() - bl != 1) begin n_err++; $display("FAIL resume_load: got %0d pulses want 1", load_q.size() - bl); end
    n_vec++; if (fcnt0 !== 8'd3) begin n_err++; $display("FAIL resume_cnt: got %0d want 3", fcnt0); end
    for (int i = 0; i < exp0_q.size(); i++) begin
      n_vec++;
      if (b0 + i >= obs0_q.size() || obs0_q[b0+i] !== exp0_q[i] ||
          b1 + i >= obs1_q.size() || obs1_q[b1+i] !== exp1_q[i]) begin
        n_err++; $display("FAIL resume_pix[%0d]: got %h/%h want %h/%h", i,
                          (b0 + i < obs0_q.size()) ? obs0_q[b0+i] : 16'hxxxx,
                          (b1 + i < obs1_q.size()) ? obs1_q[b1+i] : 16'hxxxx, exp0_q[i], exp1_q[i]);
      end
    end
  endtask

  task automatic test_rst_mid_line();
    int b0;
    send_vsync();
    fill_line(8'hE0);
    for (int i = 0; i < 4; i++) begin cmos_href = 1'b1; cmos_data = lb[i]; step(); end
    rst = 1'b1;
    step();
    n_vec++; if (we0 !== 1'b0) begin n_err++; $display("FAIL rst_pix_we: got %b want 0", we0); end
    n_vec++; if (data0 !== 16'h0000) begin n_err++; $display("FAIL rst_pix_data: got %h want 0000", data0); end
    n_vec++; if (load0 !== 1'b0) begin n_err++; $display("FAIL rst_load: got %b want 0", load0); end
    n_vec++; if (cap0 !== 1'b0) begin n_err++; $display("FAIL rst_capture_on: got %b want 0", cap0); end
    n_vec++; if (fcnt0 !== 8'd0) begin n_err++; $display("FAIL rst_frame_cnt: got %0d want 0", fcnt0); end
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL rst_line_err: got %b want 0", err0); end
    n_vec++; if (st0 !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", st0); end
    rst = 1'b0;
    b0 = obs0_q.size();
    for (int i = 4; i < 12; i++) begin cmos_href = 1'b1; cmos_data = lb[i]; step(); end
    cmos_href = 1'b0;
    repeat (4) step();
    n_vec++; if (obs0_q.size() - b0 != 0) begin n_err++; $display("FAIL rst_after_we: got %0d strobes want 0", obs0_q.size() - b0); end
    n_vec++; if (cap0 !== 1'b0) begin n_err++; $display("FAIL rst_after_capture: got %b want 0", cap0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_skip_capture();
    test_byte_order();
    test_odd_line();
    test_extra_line();
    test_init_drop();
    test_rst_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
